// File: rtl/dp_pkg.sv
// Shared codes for the sequenced datapath: ALU ops, B-shift modes, sequencer states, status bits.
package dp_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_e;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;

endpackage

// File: rtl/seq_datapath_if.sv
// Instruction, external-load and result bundle between decoder/memory-load path and seq_datapath.
interface seq_datapath_if #(
    parameter int WIDTH  = 16,
    parameter int REG_AW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [REG_AW-1:0] rd;
    logic [1:0]        shift;
    logic              use_imm;
    logic              a_zero;
    logic [WIDTH-1:0]  imm;
    logic              ext_wr;
    logic [REG_AW-1:0] ext_addr;
    logic [WIDTH-1:0]  ext_data;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic [2:0]        status;
    logic              busy;

    modport master (
        output in_valid, alu_op, rn, rm, rd, shift, use_imm, a_zero, imm,
               ext_wr, ext_addr, ext_data,
        input  in_ready, done, result, status, busy
    );

    modport slave (
        input  in_valid, alu_op, rn, rm, rd, shift, use_imm, a_zero, imm,
               ext_wr, ext_addr, ext_data,
        output in_ready, done, result, status, busy
    );
endinterface

// File: rtl/dp_regfile.sv
// Purpose: NREGS x WIDTH register file, one write port, one async read port.
// Latency: write visible on read port the cycle after we; read is combinational.
// Backpressure: none; a write is taken whenever we is high.
module dp_regfile #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [REG_AW-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/seq_datapath.sv
// Purpose: multi-cycle ALU datapath (regfile, A/B/C latches, shifter, ALU, status) with own sequencer.
// Latency: accept -> done after 4 edges; one op per 5 cycles. SEQ_DATAPATH_OVF_EN enables the V flag.
// Backpressure: in_ready only in IDLE with no ext_wr; ext_wr while busy is dropped.
module seq_datapath
    import dp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic         clk,
    input  logic         reset,
    seq_datapath_if.slave bus
);
    localparam int REG_AW = $clog2(NREGS);

    typedef struct packed {
        alu_op_e           op;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rm;
        logic [REG_AW-1:0] rd;
        shift_e            sh;
        logic              use_imm;
        logic              a_zero;
        logic [WIDTH-1:0]  imm;
    } instr_t;

    state_e            state;
    instr_t            ins;
    logic [WIDTH-1:0]  a_q, b_q, c_q;
    logic [2:0]        status_q;
    logic              done_q, busy_q;

    logic              accept;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr, rf_raddr;
    logic [WIDTH-1:0]  rf_wdata, rf_rdata;
    logic [WIDTH-1:0]  ain, bin, b_sh, c_next;
    logic              v_next;

    assign bus.in_ready = (state == IDLE) && !bus.ext_wr;
    assign accept       = bus.in_valid && bus.in_ready;

    // Single read port is time-shared: rn in RD_A, rm in RD_B.
    assign rf_raddr = (state == RD_A) ? ins.rn : ins.rm;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = bus.ext_addr;
        rf_wdata = bus.ext_data;
        if (state == WB) begin
            rf_we    = 1'b1;
            rf_waddr = ins.rd;
            rf_wdata = c_q;
        end else if (state == IDLE && bus.ext_wr) begin
            rf_we = 1'b1;
        end
    end

    dp_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .REG_AW(REG_AW)
    ) u_regfile (
        .clk  (clk),
        .reset(reset),
        .we   (rf_we),
        .waddr(rf_waddr),
        .wdata(rf_wdata),
        .raddr(rf_raddr),
        .rdata(rf_rdata)
    );

    always_comb begin
        b_sh = b_q;
        case (ins.sh)
            SH_NONE: b_sh = b_q;
            SH_LSL1: b_sh = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR1: b_sh = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR1: b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
        endcase
    end

    assign ain = ins.a_zero  ? '0      : a_q;
    assign bin = ins.use_imm ? ins.imm : b_sh;

    always_comb begin
        c_next = '0;
        case (ins.op)
            ALU_ADD:  c_next = ain + bin;
            ALU_SUB:  c_next = ain - bin;
            ALU_AND:  c_next = ain & bin;
            ALU_NOTB: c_next = ~bin;
        endcase
    end

`ifdef SEQ_DATAPATH_OVF_EN
    always_comb begin
        v_next = 1'b0;
        case (ins.op)
            ALU_ADD: v_next = (ain[WIDTH-1] == bin[WIDTH-1]) && (c_next[WIDTH-1] != ain[WIDTH-1]);
            ALU_SUB: v_next = (ain[WIDTH-1] != bin[WIDTH-1]) && (c_next[WIDTH-1] != ain[WIDTH-1]);
            default: v_next = 1'b0;
        endcase
    end
`else
    assign v_next = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ins      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ins.op      <= alu_op_e'(bus.alu_op);
                        ins.rn      <= bus.rn;
                        ins.rm      <= bus.rm;
                        ins.rd      <= bus.rd;
                        ins.sh      <= shift_e'(bus.shift);
                        ins.use_imm <= bus.use_imm;
                        ins.a_zero  <= bus.a_zero;
                        ins.imm     <= bus.imm;
                        busy_q      <= 1'b1;
                        state       <= RD_A;
                    end
                end
                RD_A: begin
                    a_q   <= rf_rdata;
                    state <= RD_B;
                end
                RD_B: begin
                    b_q   <= rf_rdata;
                    state <= EXEC;
                end
                EXEC: begin
                    c_q              <= c_next;
                    status_q[STAT_Z] <= (c_next == '0);
                    status_q[STAT_N] <= c_next[WIDTH-1];
                    status_q[STAT_V] <= v_next;
                    done_q           <= 1'b1;
                    state            <= WB;
                end
                WB: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.done   = done_q;
    assign bus.result = c_q;
    assign bus.status = status_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench for seq_datapath: expected {status,result} queued at accept, checked at done.
module tb_seq_datapath;
    localparam int W  = 16;
    localparam int AW = 3;
`ifdef SEQ_DATAPATH_OVF_EN
    localparam logic [2:0] OVF_STAT = 3'b110;
`else
    localparam logic [2:0] OVF_STAT = 3'b010;
`endif

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [W+2:0] sb[$];
    logic [W-1:0] mdl [8];

    seq_datapath_if #(.WIDTH(W), .REG_AW(AW)) bif ();

    seq_datapath #(.WIDTH(W), .NREGS(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] shf(input logic [W-1:0] b, input logic [1:0] sh);
        case (sh)
            2'b01:   return {b[W-2:0], 1'b0};
            2'b10:   return {1'b0, b[W-1:1]};
            2'b11:   return {b[W-1], b[W-1:1]};
            default: return b;
        endcase
    endfunction

    function automatic logic [W+2:0] model_alu(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W-1:0] c;
        logic         v;
        case (op)
            2'b00:   c = a + b;
            2'b01:   c = a - b;
            2'b10:   c = a & b;
            default: c = ~b;
        endcase
        v = 1'b0;
`ifdef SEQ_DATAPATH_OVF_EN
        if (op == 2'b00)      v = (a[W-1] == b[W-1]) && (c[W-1] != a[W-1]);
        else if (op == 2'b01) v = (a[W-1] != b[W-1]) && (c[W-1] != a[W-1]);
`endif
        return {v, c[W-1], (c == '0), c};
    endfunction

    task automatic ext(input logic [AW-1:0] a, input logic [W-1:0] d);
        bif.ext_wr   = 1'b1;
        bif.ext_addr = a;
        bif.ext_data = d;
        tick();
        bif.ext_wr = 1'b0;
        mdl[a]     = d;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] rn, input logic [AW-1:0] rm,
                         input logic [AW-1:0] rd, input logic [1:0] sh, input logic ui,
                         input logic az, input logic [W-1:0] imm, output int waited);
        logic [W-1:0] a, b;
        logic [W+2:0] e;
        bif.alu_op  = op;
        bif.rn      = rn;
        bif.rm      = rm;
        bif.rd      = rd;
        bif.shift   = sh;
        bif.use_imm = ui;
        bif.a_zero  = az;
        bif.imm     = imm;
        bif.in_valid = 1'b1;
        #1;
        waited = 0;
        while (!bif.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("in_ready", {31'd0, bif.in_ready}, 32'd1);
        a = az ? '0 : mdl[rn];
        b = ui ? imm : shf(mdl[rm], sh);
        e = model_alu(op, a, b);
        sb.push_back(e);
        tick();
        bif.in_valid = 1'b0;
        mdl[rd] = e[W-1:0];
    endtask

    task automatic wait_done(input string tag, output int lat);
        logic [W+2:0] e;
        lat = 1;
        while (!bif.done && lat < 12) begin
            tick();
            lat++;
        end
        chk({tag, "_done"}, {31'd0, bif.done}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_res"}, {16'd0, bif.result}, {16'd0, e[W-1:0]});
            chk({tag, "_stat"}, {29'd0, bif.status}, {29'd0, e[W+2:W]});
        end
        tick();
    endtask

    task automatic read_reg(input string tag, input logic [AW-1:0] r, output logic [W-1:0] val);
        int w, l;
        issue(2'b00, 3'd0, r, r, 2'b00, 1'b0, 1'b1, '0, w);
        wait_done(tag, l);
        val = bif.result;
    endtask

    initial begin
        int           w, lat;
        logic [W-1:0] v;
        logic         any_done;

        for (int i = 0; i < 8; i++) mdl[i] = '0;
        reset        = 1'b1;
        bif.in_valid = 1'b0;
        bif.alu_op   = '0;
        bif.rn       = '0;
        bif.rm       = '0;
        bif.rd       = '0;
        bif.shift    = '0;
        bif.use_imm  = 1'b0;
        bif.a_zero   = 1'b0;
        bif.imm      = '0;
        bif.ext_wr   = 1'b0;
        bif.ext_addr = '0;
        bif.ext_data = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("rst_done", {31'd0, bif.done}, 32'd0);
        chk("rst_result", {16'd0, bif.result}, 32'd0);
        chk("rst_status", {29'd0, bif.status}, 32'd0);
        chk("rst_ready", {31'd0, bif.in_ready}, 32'd1);

        // 1: basic add, latency and throughput
        ext(3'd0, 16'd7);
        ext(3'd1, 16'd2);
        issue(2'b00, 3'd0, 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, '0, w);
        chk("t1_busy", {31'd0, bif.busy}, 32'd1);
        wait_done("t1", lat);
        chk("t1_lat", lat, 32'd4);
        chk("t1_result", {16'd0, bif.result}, 32'd9);
        chk("t1_status", {29'd0, bif.status}, 32'd0);
        chk("t1_thru_rdy", {31'd0, bif.in_ready}, 32'd1);
        read_reg("t1_r2", 3'd2, v);
        chk("t1_r2_val", {16'd0, v}, 32'd9);

        // 2: sub to zero, then and with immediate
        ext(3'd3, 16'd5);
        issue(2'b01, 3'd3, 3'd3, 3'd4, 2'b00, 1'b0, 1'b0, '0, w);
        wait_done("t2_sub", lat);
        chk("t2_sub_status", {29'd0, bif.status}, 32'd1);
        ext(3'd7, 16'hFFFF);
        issue(2'b10, 3'd7, 3'd0, 3'd5, 2'b00, 1'b1, 1'b0, 16'h00F0, w);
        wait_done("t2_and", lat);
        chk("t2_and_result", {16'd0, bif.result}, 32'h00F0);
        chk("t2_and_status", {29'd0, bif.status}, 32'd0);

        // 3: shifter paths
        ext(3'd4, 16'h8000);
        issue(2'b00, 3'd0, 3'd4, 3'd6, 2'b11, 1'b0, 1'b1, '0, w);
        wait_done("t3_asr", lat);
        chk("t3_asr_result", {16'd0, bif.result}, 32'hC000);
        chk("t3_asr_n", {31'd0, bif.status[1]}, 32'd1);
        issue(2'b00, 3'd0, 3'd4, 3'd6, 2'b10, 1'b0, 1'b1, '0, w);
        wait_done("t3_lsr", lat);
        chk("t3_lsr_result", {16'd0, bif.result}, 32'h4000);
        chk("t3_lsr_n", {31'd0, bif.status[1]}, 32'd0);
        issue(2'b11, 3'd0, 3'd4, 3'd6, 2'b01, 1'b0, 1'b0, '0, w);
        wait_done("t3_notlsl", lat);

        // 4: signed overflow
        ext(3'd5, 16'h7FFF);
        issue(2'b00, 3'd5, 3'd0, 3'd6, 2'b00, 1'b1, 1'b0, 16'h0001, w);
        wait_done("t4", lat);
        chk("t4_result", {16'd0, bif.result}, 32'h8000);
        chk("t4_status", {29'd0, bif.status}, {29'd0, OVF_STAT});
        issue(2'b01, 3'd4, 3'd0, 3'd6, 2'b00, 1'b1, 1'b0, 16'h0001, w);
        wait_done("t4_sub", lat);

        // 5a: ext_wr while busy is dropped
        issue(2'b00, 3'd1, 3'd1, 3'd6, 2'b00, 1'b0, 1'b0, '0, w);
        tick();
        bif.ext_wr   = 1'b1;
        bif.ext_addr = 3'd0;
        bif.ext_data = 16'h1234;
        tick();
        bif.ext_wr = 1'b0;
        wait_done("t5a_op", lat);
        read_reg("t5a_r0", 3'd0, v);
        chk("t5a_r0_val", {16'd0, v}, 32'd7);

        // 5b: ext_wr beats in_valid in IDLE, op taken next cycle
        bif.ext_wr   = 1'b1;
        bif.ext_addr = 3'd6;
        bif.ext_data = 16'd3;
        bif.alu_op   = 2'b00;
        bif.a_zero   = 1'b1;
        bif.use_imm  = 1'b0;
        bif.shift    = 2'b00;
        bif.rm       = 3'd6;
        bif.rd       = 3'd7;
        bif.in_valid = 1'b1;
        #1;
        chk("t5b_ready_low", {31'd0, bif.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("t5b_not_busy", {31'd0, bif.busy}, 32'd0);
        bif.ext_wr = 1'b0;
        mdl[6]     = 16'd3;
        issue(2'b00, 3'd0, 3'd6, 3'd7, 2'b00, 1'b0, 1'b1, '0, w);
        chk("t5b_waited", w, 32'd0);
        wait_done("t5b", lat);
        chk("t5b_result", {16'd0, bif.result}, 32'd3);

        // 6: reset during EXEC aborts the op
        issue(2'b00, 3'd0, 3'd1, 3'd3, 2'b00, 1'b0, 1'b0, '0, w);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        chk("t6_busy", {31'd0, bif.busy}, 32'd0);
        chk("t6_result", {16'd0, bif.result}, 32'd0);
        chk("t6_status", {29'd0, bif.status}, 32'd0);
        any_done = bif.done;
        for (int i = 0; i < 6; i++) begin
            tick();
            any_done = any_done | bif.done;
        end
        chk("t6_no_done", {31'd0, any_done}, 32'd0);
        read_reg("t6_r3", 3'd3, v);
        chk("t6_r3_val", {16'd0, v}, 32'd0);

        // Random ops against the model
        for (int i = 0; i < 6; i++) ext(3'(i), 16'($urandom));
        for (int i = 0; i < 16; i++) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom), w);
            wait_done("rnd", lat);
            chk("rnd_lat", lat, 32'd4);
        end
        for (int r = 0; r < 8; r++) begin
            read_reg("rnd_rd", 3'(r), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
